// File: rtl/rx_fcs_check.sv
// Per-frame CRC-32 FCS checker with length/runt/oversize flags and saturating good/bad counters.
// Latency: frame_done pulses 1 cycle after the first in_en-low cycle that follows the last byte.
// Backpressure: none; pure observer of the receive byte stream, in_en is never stalled.
module rx_fcs_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic        clk125MHz,
    input  logic        RST,
    input  logic [7:0]  in_data,
    input  logic        in_en,
    output logic        frame_done,
    output logic        fcs_ok,
    output logic        runt,
    output logic        oversize,
    output logic [15:0] frame_len,
    output logic [31:0] good_cnt,
    output logic [31:0] bad_cnt
);

    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L   = 16'(MAX_LEN);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        RECV = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] crc;
    logic [15:0] len;
    logic        end_frame;
    logic        fcs_c;
    logic        runt_c;
    logic        over_c;
    logic        good_c;

    // Reflected CRC-32 byte update, LSB of the byte first, 8 unrolled bit steps.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    // State register; reset lands in SYNC so a frame already in flight is ignored.
    always_ff @(posedge clk125MHz) begin
        if (RST) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: SYNC waits for a gap, IDLE waits for a first byte, RECV waits for the gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (!in_en) state_d = IDLE;
            IDLE:    if (in_en)  state_d = RECV;
            RECV:    if (!in_en) state_d = IDLE;
            default: state_d = SYNC;
        endcase
    end

    // Frame verdict, evaluated from the running CRC and the saturated length at frame end.
    always_comb begin
        end_frame = (state_q == RECV) && !in_en;
        runt_c    = (len < MIN_L);
        over_c    = (len > MAX_L);
        fcs_c     = (crc == RESIDUE) && (len >= 16'd4);
        good_c    = fcs_c && !runt_c && !over_c;
    end

    // Datapath: running CRC and length, result latching and saturating counters.
    always_ff @(posedge clk125MHz) begin
        if (RST) begin
            crc        <= 32'hFFFFFFFF;
            len        <= 16'd0;
            frame_done <= 1'b0;
            fcs_ok     <= 1'b0;
            runt       <= 1'b0;
            oversize   <= 1'b0;
            frame_len  <= 16'd0;
            good_cnt   <= 32'd0;
            bad_cnt    <= 32'd0;
        end else begin
            frame_done <= 1'b0;
            if (state_q == IDLE && in_en) begin
                crc <= crc_byte(32'hFFFFFFFF, in_data);
                len <= 16'd1;
            end else if (state_q == RECV && in_en) begin
                crc <= crc_byte(crc, in_data);
                if (len != 16'hFFFF) begin
                    len <= len + 16'd1;
                end
            end
            if (end_frame) begin
                frame_done <= 1'b1;
                fcs_ok     <= fcs_c;
                runt       <= runt_c;
                oversize   <= over_c;
                frame_len  <= len;
                if (good_c) begin
                    if (good_cnt != 32'hFFFFFFFF) good_cnt <= good_cnt + 32'd1;
                end else begin
                    if (bad_cnt != 32'hFFFFFFFF) bad_cnt <= bad_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_fcs_check.sv
// Directed testbench for rx_fcs_check: known CRC, corruption, back-to-back, size limits, reset.
// Latency: results sampled on the falling edge after frame_done rises.
// Backpressure: none; stimulus drives in_en freely.
module tb_rx_fcs_check;

    logic        clk125MHz = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_en = 1'b0;
    logic        frame_done;
    logic        fcs_ok;
    logic        runt;
    logic        oversize;
    logic [15:0] frame_len;
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [15:0] last_len = 16'd0;
    logic [15:0] prev_len = 16'd0;
    logic [7:0]  frm [];

    rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
        .clk125MHz (clk125MHz),
        .RST       (RST),
        .in_data   (in_data),
        .in_en     (in_en),
        .frame_done(frame_done),
        .fcs_ok    (fcs_ok),
        .runt      (runt),
        .oversize  (oversize),
        .frame_len (frame_len),
        .good_cnt  (good_cnt),
        .bad_cnt   (bad_cnt)
    );

    always #4 clk125MHz = ~clk125MHz;

    // Pulse monitor: counts frame_done cycles and remembers the last two lengths.
    always @(negedge clk125MHz) begin
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            prev_len <= last_len;
            last_len <= frame_len;
        end
    end

    // Bit-serial reference FCS (with final inversion) used to build valid frames.
    function automatic logic [31:0] ref_fcs(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    // Fill frm with n_data counting bytes starting at base, then append the FCS LSB first.
    task automatic build_frame(input int n_data, input logic [7:0] base);
        logic [31:0] f;
        frm = new[n_data + 4];
        for (int i = 0; i < n_data; i++) frm[i] = 8'(base + 8'(i));
        f = ref_fcs(n_data);
        for (int k = 0; k < 4; k++) frm[n_data + k] = f[8*k +: 8];
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk125MHz);
            in_en   = 1'b1;
            in_data = frm[i];
        end
        @(negedge clk125MHz);
        in_en   = 1'b0;
        in_data = 8'h00;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk125MHz);
    endtask

    task automatic do_reset();
        @(negedge clk125MHz);
        RST = 1'b1;
        @(negedge clk125MHz);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0b want 0", frame_done); end
        checks++; if (fcs_ok !== 1'b0) begin errors++; $display("FAIL reset_fcs_ok got %0b want 0", fcs_ok); end
        checks++; if (runt !== 1'b0 || oversize !== 1'b0) begin errors++; $display("FAIL reset_flags got runt=%0b over=%0b want 0 0", runt, oversize); end
        checks++; if (frame_len !== 16'd0) begin errors++; $display("FAIL reset_frame_len got %0d want 0", frame_len); end
        checks++; if (good_cnt !== 32'd0 || bad_cnt !== 32'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", good_cnt, bad_cnt); end
    endtask

    task automatic test_known_crc();
        int d0;
        do_reset();
        frm = new[13];
        for (int i = 0; i < 9; i++) frm[i] = 8'(8'h31 + 8'(i));
        frm[9] = 8'h26; frm[10] = 8'h39; frm[11] = 8'hF4; frm[12] = 8'hCB;
        d0 = done_cnt;
        send_frame(13);
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL known_early_done got %0b want 0", frame_done); end
        @(negedge clk125MHz);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL known_latency frame_done got %0b want 1", frame_done); end
        settle();
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL known_pulses got %0d want 1", done_cnt - d0); end
        checks++; if (fcs_ok !== 1'b1) begin errors++; $display("FAIL known_fcs_ok got %0b want 1", fcs_ok); end
        checks++; if (frame_len !== 16'd13) begin errors++; $display("FAIL known_len got %0d want 13", frame_len); end
        checks++; if (runt !== 1'b1 || oversize !== 1'b0) begin errors++; $display("FAIL known_flags got runt=%0b over=%0b want 1 0", runt, oversize); end
        checks++; if (bad_cnt !== 32'd1 || good_cnt !== 32'd0) begin errors++; $display("FAIL known_counters got good=%0d bad=%0d want 0 1", good_cnt, bad_cnt); end
    endtask

    task automatic test_corrupt();
        do_reset();
        build_frame(60, 8'h00);
        send_frame(64);
        settle();
        checks++; if (fcs_ok !== 1'b1) begin errors++; $display("FAIL corrupt_clean_fcs got %0b want 1", fcs_ok); end
        checks++; if (frame_len !== 16'd64 || runt !== 1'b0) begin errors++; $display("FAIL corrupt_clean_len got %0d runt=%0b want 64 0", frame_len, runt); end
        checks++; if (good_cnt !== 32'd1) begin errors++; $display("FAIL corrupt_clean_good got %0d want 1", good_cnt); end
        frm[10] = frm[10] ^ 8'h01;
        send_frame(64);
        settle();
        checks++; if (fcs_ok !== 1'b0) begin errors++; $display("FAIL corrupt_bad_fcs got %0b want 0", fcs_ok); end
        checks++; if (bad_cnt !== 32'd1 || good_cnt !== 32'd1) begin errors++; $display("FAIL corrupt_counters got good=%0d bad=%0d want 1 1", good_cnt, bad_cnt); end
    endtask

    task automatic test_back_to_back();
        int d0;
        do_reset();
        build_frame(60, 8'h40);
        d0 = done_cnt;
        send_frame(64);
        send_frame(64);
        settle();
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", done_cnt - d0); end
        checks++; if (prev_len !== 16'd64 || last_len !== 16'd64) begin errors++; $display("FAIL b2b_lens got %0d,%0d want 64,64", prev_len, last_len); end
        checks++; if (good_cnt !== 32'd2 || bad_cnt !== 32'd0) begin errors++; $display("FAIL b2b_counters got good=%0d bad=%0d want 2 0", good_cnt, bad_cnt); end
    endtask

    task automatic test_size_limits();
        do_reset();
        build_frame(59, 8'h10);
        send_frame(63);
        settle();
        checks++; if (runt !== 1'b1 || fcs_ok !== 1'b1 || bad_cnt !== 32'd1) begin errors++; $display("FAIL runt63 got runt=%0b fcs=%0b bad=%0d want 1 1 1", runt, fcs_ok, bad_cnt); end
        build_frame(1518, 8'h20);
        send_frame(1522);
        settle();
        checks++; if (oversize !== 1'b0 || frame_len !== 16'd1522 || good_cnt !== 32'd1) begin errors++; $display("FAIL max1522 got over=%0b len=%0d good=%0d want 0 1522 1", oversize, frame_len, good_cnt); end
        build_frame(1519, 8'h30);
        send_frame(1523);
        settle();
        checks++; if (oversize !== 1'b1 || frame_len !== 16'd1523) begin errors++; $display("FAIL over1523 got over=%0b len=%0d want 1 1523", oversize, frame_len); end
        checks++; if (bad_cnt !== 32'd2 || good_cnt !== 32'd1) begin errors++; $display("FAIL over1523_counters got good=%0d bad=%0d want 1 2", good_cnt, bad_cnt); end
        frm = new[70000];
        for (int i = 0; i < 70000; i++) frm[i] = 8'(i);
        send_frame(70000);
        settle();
        checks++; if (frame_len !== 16'hFFFF || oversize !== 1'b1) begin errors++; $display("FAIL sat70000 got len=%0h over=%0b want ffff 1", frame_len, oversize); end
        checks++; if (bad_cnt !== 32'd3) begin errors++; $display("FAIL sat70000_bad got %0d want 3", bad_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        do_reset();
        build_frame(60, 8'h55);
        send_frame(64);
        settle();
        d0 = done_cnt;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk125MHz);
            in_en   = 1'b1;
            in_data = frm[i];
            RST     = (i == 29);
        end
        @(negedge clk125MHz);
        in_en = 1'b0;
        RST   = 1'b0;
        settle();
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL midrst_pulses got %0d want 0", done_cnt - d0); end
        checks++; if (good_cnt !== 32'd0 || bad_cnt !== 32'd0 || frame_len !== 16'd0) begin errors++; $display("FAIL midrst_clear got good=%0d bad=%0d len=%0d want 0 0 0", good_cnt, bad_cnt, frame_len); end
        send_frame(64);
        settle();
        checks++; if (good_cnt !== 32'd1 || done_cnt - d0 !== 1) begin errors++; $display("FAIL midrst_next got good=%0d pulses=%0d want 1 1", good_cnt, done_cnt - d0); end
    endtask

    task automatic test_degenerate();
        do_reset();
        frm = new[3];
        frm[0] = 8'hA5; frm[1] = 8'h3C; frm[2] = 8'hFF;
        send_frame(1);
        settle();
        checks++; if (fcs_ok !== 1'b0 || runt !== 1'b1 || frame_len !== 16'd1) begin errors++; $display("FAIL deg1 got fcs=%0b runt=%0b len=%0d want 0 1 1", fcs_ok, runt, frame_len); end
        send_frame(3);
        settle();
        checks++; if (fcs_ok !== 1'b0 || runt !== 1'b1 || frame_len !== 16'd3) begin errors++; $display("FAIL deg3 got fcs=%0b runt=%0b len=%0d want 0 1 3", fcs_ok, runt, frame_len); end
        checks++; if (bad_cnt !== 32'd2 || good_cnt !== 32'd0) begin errors++; $display("FAIL deg_counters got good=%0d bad=%0d want 0 2", good_cnt, bad_cnt); end
    endtask

    initial begin
        test_reset();
        test_known_crc();
        test_corrupt();
        test_back_to_back();
        test_size_limits();
        test_reset_mid_frame();
        test_degenerate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_fcs_check.md
Name: rx_fcs_check

Overview:
- Per-frame CRC-32 (IEEE 802.3 FCS) checker on the 125 MHz receive byte stream, after preamble/SFD removal.
- Runs in parallel with the FCS-stripping stage and feeds detect_errors2 and the VIO.
- For each frame it reports FCS good/bad, byte length, runt and oversize flags, and keeps saturating good/bad frame counters.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes, including FCS; shorter frames are flagged runt.
- MAX_LEN, 1522, maximum legal frame length in bytes, including FCS; longer frames are flagged oversize.

Ports:
- clk125MHz  in  1  system clock; all logic runs on its rising edge.
- RST  in  1  synchronous, active-high reset.
- in_data  in  8  frame byte: destination MAC through last FCS byte, bit 0 first on the wire.
- in_en  in  1  high for every valid byte of a frame, contiguous; low for at least 1 cycle between frames.
- frame_done  out  1  single-cycle pulse; the result outputs below are valid in this cycle.
- fcs_ok  out  1  CRC residue matched.
- runt  out  1  frame_len < MIN_LEN.
- oversize  out  1  frame_len > MAX_LEN.
- frame_len  out  16  byte count of the frame, FCS included.
- good_cnt  out  32  count of frames with fcs_ok=1, runt=0, oversize=0.
- bad_cnt  out  32  count of all other completed frames.

Behaviour:
- Reset and clocking: the clock is clk125MHz; RST is synchronous and active-high.
- Reset values: frame_done=0, fcs_ok=0, runt=0, oversize=0, frame_len=0, good_cnt=0, bad_cnt=0. The FSM enters SYNC.
- FSM states: SYNC, IDLE, RECV.
  - SYNC: wait for in_en sampled 0, then go to IDLE. This discards any partial frame in progress when reset is released.
  - IDLE: when in_en=1, go to RECV. The first byte is consumed on that same edge: crc is initialised to 0xFFFFFFFF and updated with the byte; len becomes 1.
  - RECV: when in_en=1, crc and len update. When in_en=0, the frame ends: results are latched, frame_done=1 for the next cycle, and the FSM returns to IDLE.
- Back-to-back frames: a new frame may begin on the cycle immediately after the frame_done cycle. A 1-cycle in_en gap between frames must be handled.
- CRC arithmetic:
  - Reflected CRC-32, polynomial 0xEDB88320, byte-wide combinational update (8 unrolled bit steps), LSB of the byte first.
  - The running register covers data and FCS bytes, with no final XOR.
  - fcs_ok=1 iff the register equals 0xDEBB20E3 at frame end.
- Short frames: a frame shorter than 4 bytes forces fcs_ok=0.
- Length counter: 16 bits, saturating at 0xFFFF with no wrap. runt and oversize are computed from the saturated value.
- Result outputs: fcs_ok, runt, oversize and frame_len are registered and hold their values until the next frame_done. frame_done itself is high for 1 cycle only.
- Latency: frame_done is asserted 1 cycle after the first cycle in which in_en is low following the last frame byte.
- Counters:
  - good_cnt or bad_cnt increments on the same edge that raises frame_done; exactly one of them increments per frame.
  - Both saturate at 0xFFFFFFFF.
  - Counters clear only on RST.
- Reset mid-frame: the frame is discarded, no frame_done is produced, and all outputs and counters clear. The FSM then passes through SYNC.
- The block is a pure observer with no backpressure; in_en is never stalled.

Test Plan:
- Known CRC: send the 13 bytes "123456789" then 0x26 0x39 0xF4 0xCB with in_en contiguous -> one frame_done pulse; fcs_ok=1, frame_len=13, runt=1, oversize=0, bad_cnt=1, good_cnt=0.
- Corrupted byte: send 60 bytes of 0x00..0x3B plus the correct FCS, then repeat with byte 10 XORed with 0x01 -> first frame: fcs_ok=1, frame_len=64, good_cnt=1; second frame: fcs_ok=0, bad_cnt=1.
- Back-to-back: two valid 64-byte frames separated by a 1-cycle in_en gap -> two frame_done pulses, good_cnt=2, and no merging of the frames.
- Oversize and saturation: a 1523-byte frame -> oversize=1, frame_len=1523, bad_cnt increments. A 70000-byte frame -> frame_len=0xFFFF.
- Reset mid-frame: assert RST for 1 cycle during byte 30 of 64 while in_en stays high to the end of the frame -> no frame_done; counters are 0. The next full valid frame -> good_cnt=1.
- Degenerate frames: 1-byte and 3-byte frames -> fcs_ok=0, runt=1, frame_len=1 and 3 respectively; bad_cnt=2.
